// File: rtl/dmem_if.sv
// Bus bundle between the core, the debug/IO requester, the arbiter and the
// single-port data memory. The arbiter sits on the slave modport; whoever
// drives requests and models the memory uses the master modport.
interface dmem_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the core has priority, but a debug requester that has
// been refused STARVE_MAX consecutive cycles wins the next slot. One command
// per cycle to a single-port synchronous RAM; load data returns one cycle
// after the grant and is steered to whichever requester issued the read.
//
// state  | meaning
// R_NONE | no read in flight, both rvalid outputs low
// R_CPU  | memory is returning a core load this cycle
// R_DBG  | memory is returning a debug load this cycle
module dmem_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic   CLK,
  input logic   RESET,
  dmem_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {R_NONE, R_CPU, R_DBG} ret_t;

  ret_t       ret;
  logic [3:0] starve_cnt;
  logic       cpu_rvalid_q;
  logic       dbg_rvalid_q;
  logic       cpu_grant;
  logic       dbg_grant;

  // Grant decision; reset masks everything so no command leaks out while held.
  always_comb begin
    cpu_grant = ~RESET & bus.cpu_req & (starve_cnt < STARVE_LIM);
    dbg_grant = ~RESET & bus.dbg_req & ~cpu_grant;
  end

  // Memory command mux from the current grant, zeroed when idle.
  always_comb begin
    bus.mem_en    = cpu_grant | dbg_grant;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    if (cpu_grant) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (dbg_grant) begin
      bus.mem_we    = bus.dbg_we;
      bus.mem_addr  = bus.dbg_addr;
      bus.mem_wdata = bus.dbg_wdata;
    end
  end

  // Handshake outputs seen by the requesters in the grant cycle.
  always_comb begin
    bus.cpu_stall = bus.cpu_req & ~cpu_grant & ~RESET;
    bus.dbg_gnt   = dbg_grant;
  end

  // Return-path FSM and starvation counter; rvalid flags registered with it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ret          <= R_NONE;
      starve_cnt   <= 4'd0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      if (bus.dbg_req & ~dbg_grant)
        starve_cnt <= (starve_cnt >= STARVE_LIM) ? STARVE_LIM : starve_cnt + 4'd1;
      else
        starve_cnt <= 4'd0;

      if (cpu_grant & ~bus.cpu_we) begin
        ret          <= R_CPU;
        cpu_rvalid_q <= 1'b1;
        dbg_rvalid_q <= 1'b0;
      end else if (dbg_grant & ~bus.dbg_we) begin
        ret          <= R_DBG;
        cpu_rvalid_q <= 1'b0;
        dbg_rvalid_q <= 1'b1;
      end else begin
        ret          <= R_NONE;
        cpu_rvalid_q <= 1'b0;
        dbg_rvalid_q <= 1'b0;
      end
    end
  end

  // Steer RAM read data to the requester that owns this return slot.
  always_comb begin
    bus.cpu_rvalid = cpu_rvalid_q;
    bus.dbg_rvalid = dbg_rvalid_q;
    bus.cpu_rdata  = {DATA_W{1'b0}};
    bus.dbg_rdata  = {DATA_W{1'b0}};
    if (ret == R_CPU)
      bus.cpu_rdata = bus.mem_rdata;
    else if (ret == R_DBG)
      bus.dbg_rdata = bus.mem_rdata;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a bench-side RAM answers the DUT, a
// rule-level model predicts every output on each falling edge, and a few
// literal checks pin the headline scenarios.
module tb_dmem_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int SM = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dmem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Bench RAM: synchronous single port, read data held until the next read.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q = '0;
  always @(posedge CLK) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what memory should hold, who is starving, what returns next.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            m_starve = 0;
  int            m_owner  = 0;    // 0 none, 1 core, 2 debug
  logic [DW-1:0] m_data   = '0;

  always @(negedge CLK) begin
    bit            cg, dg;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    if (RESET) begin
      chk("m_rst_en",    32'(bus.mem_en),     0);
      chk("m_rst_gnt",   32'(bus.dbg_gnt),    0);
      chk("m_rst_stall", 32'(bus.cpu_stall),  0);
      chk("m_rst_crv",   32'(bus.cpu_rvalid), 0);
      chk("m_rst_drv",   32'(bus.dbg_rvalid), 0);
      chk("m_rst_crd",   bus.cpu_rdata,       0);
      chk("m_rst_drd",   bus.dbg_rdata,       0);
      m_starve = 0;
      m_owner  = 0;
    end else begin
      cg = bus.cpu_req && (m_starve < SM);
      dg = !cg && bus.dbg_req;
      e_we = 1'b0; e_addr = '0; e_wd = '0;
      if (cg) begin e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_wd = bus.cpu_wdata; end
      if (dg) begin e_we = bus.dbg_we; e_addr = bus.dbg_addr; e_wd = bus.dbg_wdata; end
      chk("m_en",    32'(bus.mem_en),    32'(cg || dg));
      chk("m_we",    32'(bus.mem_we),    32'(e_we));
      chk("m_addr",  32'(bus.mem_addr),  32'(e_addr));
      chk("m_wdata", bus.mem_wdata,      e_wd);
      chk("m_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !cg));
      chk("m_gnt",   32'(bus.dbg_gnt),   32'(dg));
      chk("m_crv",   32'(bus.cpu_rvalid), 32'(m_owner == 1));
      chk("m_drv",   32'(bus.dbg_rvalid), 32'(m_owner == 2));
      chk("m_crd",   bus.cpu_rdata, (m_owner == 1) ? m_data : 32'h0);
      chk("m_drd",   bus.dbg_rdata, (m_owner == 2) ? m_data : 32'h0);
      m_owner = 0;
      if ((cg || dg) && e_we) shadow[e_addr] = e_wd;
      if ((cg || dg) && !e_we) begin
        m_owner = cg ? 1 : 2;
        m_data  = shadow[e_addr];
      end
      if (bus.dbg_req && !dg) m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
      else                    m_starve = 0;
    end
  end

  task automatic set_in(input logic cr, input logic cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input logic dr, input logic dw,
                        input logic [AW-1:0] da, input logic [DW-1:0] dd);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dbg_req = dr; bus.dbg_we = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  logic [14:0] gnt_v, stall_v, exp_v;
  int          gcount, first_gnt;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = 32'h1000_0000 + i;
      shadow[i] = 32'h1000_0000 + i;
    end
    ram[4]    = 32'h0000_ABCD;
    shadow[4] = 32'h0000_ABCD;

    // Core request pending while reset is held must not stall or issue.
    set_in(1, 0, 7'h04, 0, 1, 0, 7'h05, 0);
    repeat (2) @(negedge CLK);
    chk("rst_stall", 32'(bus.cpu_stall), 0);
    chk("rst_gnt",   32'(bus.dbg_gnt),   0);

    // Single core load of address 0x04.
    @(posedge CLK); #1;
    RESET = 1'b0;
    set_in(1, 0, 7'h04, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("ld_stall", 32'(bus.cpu_stall), 0);
    chk("ld_addr",  32'(bus.mem_addr),  32'h04);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("ld_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("ld_rdata",  bus.cpu_rdata, 32'h0000_ABCD);

    // Both requesters held: debug wins every fifth slot.
    next_cycle();
    set_in(1, 0, 7'h04, 0, 1, 0, 7'h05, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      gnt_v[i]   = bus.dbg_gnt;
      stall_v[i] = bus.cpu_stall;
      if (i < 14) next_cycle();
    end
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    exp_v = 15'h4210;
    chk("starve_gnt",   32'(gnt_v),   32'(exp_v));
    chk("starve_stall", 32'(stall_v), 32'(exp_v));

    // Debug store then core load of the same word.
    next_cycle();
    set_in(0, 0, 0, 0, 1, 1, 7'h10, 32'hDEAD_BEEF);
    @(negedge CLK);
    chk("dst_gnt", 32'(bus.dbg_gnt), 1);
    chk("dst_we",  32'(bus.mem_we),  1);
    next_cycle();
    set_in(1, 0, 7'h10, 0, 0, 0, 0, 0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("raw_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("raw_rdata",  bus.cpu_rdata, 32'hDEAD_BEEF);

    // Short debug pulse under core load: never granted, counter forgotten.
    gcount = 0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      set_in(1, 0, 7'(i), 0, (i < 2), 0, 7'h10, 0);
      @(negedge CLK);
      gcount += int'(bus.dbg_gnt);
    end
    chk("pulse_nognt", 32'(gcount), 0);
    first_gnt = -1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      set_in(1, 0, 7'h04, 0, 1, 0, 7'h10, 0);
      @(negedge CLK);
      if (bus.dbg_gnt && first_gnt < 0) first_gnt = i;
    end
    chk("pulse_restart", 32'(first_gnt), 32'd4);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("dld_rvalid", 32'(bus.dbg_rvalid), 1);
    chk("dld_rdata",  bus.dbg_rdata, 32'hDEAD_BEEF);

    // Reset lands right after a core read grant: that return is dropped.
    next_cycle();
    set_in(1, 0, 7'h04, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("rr_grant", 32'(bus.cpu_stall), 0);
    next_cycle();
    RESET = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("rr_rvalid", 32'(bus.cpu_rvalid), 0);
    chk("rr_rdata",  bus.cpu_rdata, 0);
    next_cycle();
    RESET = 1'b0;
    @(negedge CLK);
    chk("idle_bus", {bus.mem_en, bus.mem_we, bus.cpu_stall, bus.dbg_gnt,
                     bus.cpu_rvalid, bus.dbg_rvalid, 7'(bus.mem_addr)}, 0);
    chk("idle_data", bus.mem_wdata | bus.cpu_rdata | bus.dbg_rdata, 0);

    // Core store then load back-to-back; the store itself returns nothing.
    next_cycle();
    set_in(1, 1, 7'h20, 32'h1234_5678, 0, 0, 0, 0);
    next_cycle();
    set_in(1, 0, 7'h20, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("st_norv", 32'(bus.cpu_rvalid), 0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    chk("st_rdata", bus.cpu_rdata, 32'h1234_5678);

    repeat (3) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
